// File: rtl/mips_pkg.sv
// Shared EX-stage definitions: multiply sequencer state encoding, default
// operand width and the adder carry-out reconstruction helper.
package mips_pkg;

   localparam int MIPS_WIDTH = 32;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] ABS_A  = 3'd1;
   localparam logic [2:0] ABS_B  = 3'd2;
   localparam logic [2:0] MUL    = 3'd3;
   localparam logic [2:0] NEG_LO = 3'd4;
   localparam logic [2:0] NEG_HI = 3'd5;

   // The shared Adder has no carry output, so rebuild it from the MSBs of
   // its operands and sum; only the top bit is needed, keeping this width-free.
   function automatic logic add_cout(input logic a_msb, input logic b_msb,
                                     input logic sum_msb);
      return (a_msb & b_msb) | ((a_msb | b_msb) & ~sum_msb);
   endfunction

endpackage

// File: rtl/mult_seq.sv
// MULT/MULTU sequencer: radix-2 shift-add on an external adder, owning HI/LO
// and raising a hazard stall when MFHI/MFLO meets an in-flight multiply.
module mult_seq
   import mips_pkg::*;
#(
   parameter int WIDTH = MIPS_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             flush,
   input  logic             hilo_rd,
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   input  logic [WIDTH-1:0] add_sum,
   output logic             busy,
   output logic             done,
   output logic             stall,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

   logic [2:0]       state;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] mq;
   logic             neg;
   logic             sgn_a;
   logic             sgn_b;
   logic [CNT_W-1:0] cnt;
   logic             lz;
   logic             carry;

   // Handshake: start is a request taken only when IDLE and flush is low;
   // there is no ready, a request seen while busy is simply dropped.
   // done pulses for one cycle in the cycle hi/lo first show the new result.
   assign busy  = (state != IDLE);
   assign stall = hilo_rd & (busy | start);

   always_comb begin
      add_a = '0;
      add_b = '0;
      case (state)
         ABS_A: begin
            if (sgn_a) begin
               add_a = ~mcand;
               add_b = ONE;
            end else begin
               add_a = mcand;
            end
         end
         ABS_B: begin
            if (sgn_b) begin
               add_a = ~mq;
               add_b = ONE;
            end else begin
               add_a = mq;
            end
         end
         MUL: begin
            add_a = acc;
            add_b = mq[0] ? mcand : '0;
         end
         NEG_LO: begin
            if (neg) begin
               add_a = ~mq;
               add_b = ONE;
            end else begin
               add_a = mq;
            end
         end
         NEG_HI: begin
            // The low-half negation carries into the high half only when
            // the low half was zero.
            if (neg) begin
               add_a = ~acc;
               add_b = {{(WIDTH-1){1'b0}}, lz};
            end else begin
               add_a = acc;
            end
         end
         default: begin
            add_a = '0;
            add_b = '0;
         end
      endcase
      carry = add_cout(add_a[WIDTH-1], add_b[WIDTH-1], add_sum[WIDTH-1]);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         mcand <= '0;
         acc   <= '0;
         mq    <= '0;
         neg   <= 1'b0;
         sgn_a <= 1'b0;
         sgn_b <= 1'b0;
         cnt   <= '0;
         lz    <= 1'b0;
         done  <= 1'b0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         done <= 1'b0;
         if (flush) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     state <= ABS_A;
                     mcand <= op_a;
                     mq    <= op_b;
                     acc   <= '0;
                     cnt   <= '0;
                     neg   <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                     sgn_a <= is_signed & op_a[WIDTH-1];
                     sgn_b <= is_signed & op_b[WIDTH-1];
                  end
               end
               ABS_A: begin
                  if (sgn_a) mcand <= add_sum;
                  state <= ABS_B;
               end
               ABS_B: begin
                  if (sgn_b) mq <= add_sum;
                  state <= MUL;
               end
               MUL: begin
                  // {acc,mq} <= {carry, sum, mq} >> 1
                  acc <= {carry, add_sum[WIDTH-1:1]};
                  mq  <= {add_sum[0], mq[WIDTH-1:1]};
                  cnt <= cnt + 1'b1;
                  if (cnt == CNT_LAST) state <= NEG_LO;
               end
               NEG_LO: begin
                  lz <= (mq == '0);
                  if (neg) mq <= add_sum;
                  state <= NEG_HI;
               end
               NEG_HI: begin
                  if (neg) begin
                     acc <= add_sum;
                     hi  <= add_sum;
                  end else begin
                     hi  <= acc;
                  end
                  lo    <= mq;
                  done  <= 1'b1;
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mult_seq.sv
// Unit bench for mult_seq: a local adder closes the operand loop and a
// 64-bit arithmetic reference model predicts every HI/LO pair.
module tb_mult_seq;

   localparam int W   = 32;
   localparam int LAT = W + 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic         is_signed;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         flush;
   logic         hilo_rd;
   logic [W-1:0] add_a;
   logic [W-1:0] add_b;
   logic [W-1:0] add_sum;
   logic         busy;
   logic         done;
   logic         stall;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int checks = 0;
   int errors = 0;
   logic [2*W-1:0] exp_q[$];

   mult_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
      .op_a(op_a), .op_b(op_b), .flush(flush), .hilo_rd(hilo_rd),
      .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
      .busy(busy), .done(done), .stall(stall), .hi(hi), .lo(lo)
   );

   assign add_sum = add_a + add_b;

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a,
                                              input logic [W-1:0] b,
                                              input logic s);
      logic signed [2*W-1:0] sa;
      logic signed [2*W-1:0] sb;
      if (s) begin
         sa = {{W{a[W-1]}}, a};
         sb = {{W{b[W-1]}}, b};
         return sa * sb;
      end
      return {{W{1'b0}}, a} * {{W{1'b0}}, b};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Caller sits just after an edge; the next edge is the issue edge.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s);
      start = 1'b1; is_signed = s; op_a = a; op_b = b;
      exp_q.push_back(ref_mul(a, b, s));
      step();
      start = 1'b0;
      op_a = $urandom; op_b = $urandom; is_signed = $urandom_range(0, 1);
   endtask

   task automatic wait_done(output int lat, output int busy_cyc, output bit ok);
      lat = 0; busy_cyc = 0; ok = 1'b0;
      while (lat < 3 * LAT) begin
         if (busy) busy_cyc++;
         step();
         lat++;
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic count_dones(input int cycles, output int n);
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         step();
         if (done) n++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0;
      flush = 1'b0; hilo_rd = 1'b0;
      step(); step();
      checks++;
      if ({hi, lo} !== '0) begin
         errors++; $display("FAIL reset_hilo got %h_%h want 0", hi, lo);
      end
      checks++;
      if ({busy, done, stall} !== 3'b000) begin
         errors++; $display("FAIL reset_flags busy/done/stall got %b want 000",
                             {busy, done, stall});
      end
      checks++;
      if ({add_a, add_b} !== '0) begin
         errors++; $display("FAIL idle_adder got %h/%h want 0/0", add_a, add_b);
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic run_and_check(input string name, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic s,
                                input bit check_timing);
      int lat, bc;
      bit ok;
      logic [2*W-1:0] exp;
      issue(a, b, s);
      if (check_timing) begin
         checks++;
         if (busy !== 1'b1) begin
            errors++; $display("FAIL %s busy_after_issue got %b want 1", name, busy);
         end
      end
      wait_done(lat, bc, ok);
      exp = exp_q.pop_front();
      checks++;
      if (!ok) begin
         errors++; $display("FAIL %s timeout no done within %0d cycles", name, 3 * LAT);
      end else begin
         if ({hi, lo} !== exp) begin
            errors++; $display("FAIL %s result got %h_%h want %h_%h", name,
                               hi, lo, exp[2*W-1:W], exp[W-1:0]);
         end
         if (check_timing) begin
            checks++;
            if (lat != LAT || bc != LAT || busy !== 1'b0) begin
               errors++; $display("FAIL %s timing latency %0d busy_cycles %0d busy_at_done %b want %0d %0d 0",
                                  name, lat, bc, busy, LAT, LAT);
            end
         end
      end
      step();
      checks++;
      if (done !== 1'b0) begin
         errors++; $display("FAIL %s done_width got %b want 0 one cycle later", name, done);
      end
   endtask

   task automatic test_directed();
      run_and_check("multu_7x6", 32'd7, 32'd6, 1'b0, 1'b1);
      run_and_check("mult_m3x5", 32'hFFFF_FFFD, 32'd5, 1'b1, 1'b1);
      run_and_check("multu_m3x5", 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
      run_and_check("multu_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
      run_and_check("mult_minmin", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
      run_and_check("mult_min_x_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
      run_and_check("mult_neg_x_0", 32'hFFFF_FFF0, 32'd0, 1'b1, 1'b0);
      run_and_check("mult_m1_x_m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
   endtask

   task automatic test_random();
      logic [W-1:0] a, b;
      for (int i = 0; i < 24; i++) begin
         a = $urandom;
         b = $urandom;
         if (i % 6 == 1) a = 32'h8000_0000;
         if (i % 6 == 2) b = 32'h0000_0001 << $urandom_range(0, W - 1);
         run_and_check("random", a, b, 1'($urandom_range(0, 1)), 1'b0);
      end
   endtask

   task automatic test_flush();
      int n;
      run_and_check("flush_setup", 32'd7, 32'd6, 1'b0, 1'b0);
      issue(32'd3, 32'd3, 1'b0);
      void'(exp_q.pop_back());
      for (int i = 0; i < 9; i++) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL flush_busy got %b want 0", busy);
      end
      count_dones(2 * LAT, n);
      checks++;
      if (n != 0 || {hi, lo} !== {32'd0, 32'd42}) begin
         errors++; $display("FAIL flush_effect dones %0d hilo %h_%h want 0 and 00000000_0000002a",
                            n, hi, lo);
      end
      // flush and start together: flush wins; stall still follows start.
      start = 1'b1; flush = 1'b1; hilo_rd = 1'b1; op_a = 32'd9; op_b = 32'd9;
      #1;
      checks++;
      if (stall !== 1'b1) begin
         errors++; $display("FAIL stall_on_start got %b want 1", stall);
      end
      step();
      start = 1'b0; flush = 1'b0; hilo_rd = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL flush_beats_start busy got %b want 0", busy);
      end
      run_and_check("after_flush", 32'd3, 32'd3, 1'b0, 1'b1);
   endtask

   task automatic test_back_to_back();
      int lat, bc, n;
      bit ok;
      logic [2*W-1:0] exp;
      issue(32'h0001_2345, 32'h0000_0100, 1'b0);
      for (int i = 0; i < 4; i++) step();
      start = 1'b1; op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678; is_signed = 1'b1;
      step();
      start = 1'b0;
      wait_done(lat, bc, ok);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || lat != LAT - 5 || {hi, lo} !== exp) begin
         errors++; $display("FAIL ignore_start ok %0d lat %0d hilo %h_%h want 1 %0d %h_%h",
                            ok, lat, hi, lo, LAT - 5, exp[2*W-1:W], exp[W-1:0]);
      end
      count_dones(2 * LAT, n);
      checks++;
      if (n != 0) begin
         errors++; $display("FAIL ignore_start_extra_done got %0d want 0", n);
      end
   endtask

   task automatic test_stall();
      int bad, lat;
      logic [2*W-1:0] exp;
      hilo_rd = 1'b1;
      issue(32'd1000, 32'd1000, 1'b0);
      bad = 0; lat = 0;
      while (!done && lat < 3 * LAT) begin
         if (stall !== 1'b1) bad++;
         step();
         lat++;
      end
      exp = exp_q.pop_front();
      checks++;
      if (bad != 0 || lat != LAT) begin
         errors++; $display("FAIL stall_during_op low_cycles %0d latency %0d want 0 %0d", bad, lat, LAT);
      end
      checks++;
      if (stall !== 1'b0 || {hi, lo} !== exp) begin
         errors++; $display("FAIL stall_at_done stall %b hilo %h_%h want 0 %h_%h",
                            stall, hi, lo, exp[2*W-1:W], exp[W-1:0]);
      end
      step();
      hilo_rd = 1'b0;
   endtask

   task automatic test_reset_mid();
      int n;
      issue(32'hFFFF_0000, 32'h0000_FFFF, 1'b1);
      void'(exp_q.pop_back());
      for (int i = 0; i < 19; i++) step();
      rst_n = 1'b0;
      step();
      checks++;
      if ({busy, done} !== 2'b00 || {hi, lo} !== '0) begin
         errors++; $display("FAIL reset_mid busy %b done %b hilo %h_%h want 0 0 0_0",
                            busy, done, hi, lo);
      end
      rst_n = 1'b1;
      count_dones(2 * LAT, n);
      checks++;
      if (n != 0) begin
         errors++; $display("FAIL reset_mid_done got %0d want 0", n);
      end
      run_and_check("after_reset", 32'hFFFF_FFF9, 32'd7, 1'b1, 1'b1);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_flush();
      test_back_to_back();
      test_stall();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
